// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks.
//   BYTE_W     : width of one UART character / requester byte lane.
//   tx_state_e : transmit arbiter FSM states. The enum is two bits wide so that
//                an illegal encoding exists and is explicitly recovered from.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        XFER = 2'b01
    } tx_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: starting at rr_ptr and walking upward modulo
// NUM_REQ, selects the first requester with req_valid high.
//   req_valid  [NUM_REQ] : requesters asking for the UART
//   rr_ptr     [PTR_W]   : highest-priority requester for this search
//   choice     [NUM_REQ] : one-hot winner (all zero when nobody is valid)
//   choice_idx [PTR_W]   : binary index of the winner (0 when nobody is valid)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] choice,
    output logic [PTR_W-1:0]   choice_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    always_comb begin
        choice     = '0;
        choice_idx = '0;
        found      = 1'b0;
        idx        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Explicit modulo keeps the walk correct for non-power-of-two NUM_REQ.
            idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found       = 1'b1;
                choice[idx] = 1'b1;
                choice_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmit FIFO between NUM_REQ byte-stream requesters. A
// requester owns the UART for a whole packet (until a byte with req_last is
// accepted) or until TIMEOUT_CYCLES cycles pass without a byte being accepted.
// Ownership rotates round-robin.
//   clk, rst            : clock; asynchronous active-low reset
//   req_valid/data/last : per-requester byte stream (lane i = data[8i+7:8i])
//   req_ready           : per-requester byte accept
//   uart_valid/data     : write strobe and byte into the UART FIFO
//   uart_full           : UART FIFO full, back-pressures the owner
//   grant               : one-hot current owner (zero when unowned)
//   busy                : a grant is held
//   timeout_err         : one-cycle pulse when an owner is dropped for idling
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      uart_valid,
    output logic [BYTE_W-1:0]         uart_data,
    input  logic                      uart_full,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

    tx_state_e          state_q;
    logic [NUM_REQ-1:0] grant_q;
    logic [PTR_W-1:0]   gidx_q;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic               busy_q;
    logic               timeout_q;

    logic [NUM_REQ-1:0] arb_choice;
    logic [PTR_W-1:0]   arb_idx;
    logic               in_xfer;
    logic               sel_valid;
    logic               sel_last;
    logic [BYTE_W-1:0]  sel_data;
    logic               fire;
    logic [PTR_W-1:0]   next_ptr;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr_q),
        .choice     (arb_choice),
        .choice_idx (arb_idx)
    );

    // One-hot mux of the owner's lane.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_data  = req_data[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // rst is folded in so the handshake outputs are low for the whole reset
    // window, including the cycle in which reset is asserted mid-packet.
    assign in_xfer    = rst && (state_q == XFER);
    assign req_ready  = in_xfer ? (grant_q & {NUM_REQ{~uart_full}}) : '0;
    assign uart_valid = in_xfer && sel_valid && !uart_full;
    assign uart_data  = in_xfer ? sel_data : '0;
    assign fire       = uart_valid;
    assign next_ptr   = (gidx_q == PTR_LAST) ? '0 : gidx_q + PTR_W'(1);

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            rr_ptr_q   <= '0;
            idle_cnt_q <= '0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        state_q    <= XFER;
                        grant_q    <= arb_choice;
                        gidx_q     <= arb_idx;
                        busy_q     <= 1'b1;
                        idle_cnt_q <= '0;
                    end
                end
                XFER: begin
                    // A byte accepted on the limit cycle wins over the timeout.
                    if (fire) begin
                        idle_cnt_q <= '0;
                        if (sel_last) begin
                            state_q  <= IDLE;
                            grant_q  <= '0;
                            busy_q   <= 1'b0;
                            rr_ptr_q <= next_ptr;
                        end
                    end else if (idle_cnt_q == CNT_LIMIT) begin
                        state_q    <= IDLE;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                        rr_ptr_q   <= next_ptr;
                        idle_cnt_q <= '0;
                        timeout_q  <= 1'b1;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= '0;
                    busy_q     <= 1'b0;
                    idle_cnt_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int TO      = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = 4'h0;
    logic [31:0] req_data  = 32'h0;
    logic [3:0]  req_last  = 4'h0;
    logic [3:0]  req_ready;
    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_full = 1'b0;
    logic [3:0]  grant;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .uart_valid  (uart_valid),
        .uart_data   (uart_data),
        .uart_full   (uart_full),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    typedef struct packed {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        full;
        logic [3:0]  e_ready;
        logic        e_uv;
        logic [7:0]  e_data;
        logic [3:0]  e_grant;
        logic        e_busy;
        logic        e_to;
    } vec_t;

    vec_t  tbl[$];
    string lbl[$];
    int    tests = 0;
    int    fails = 0;

    function automatic vec_t mkv(input logic r, input logic [3:0] v, input logic [31:0] d,
                                 input logic [3:0] l, input logic f, input logic [3:0] er,
                                 input logic euv, input logic [7:0] ed, input logic [3:0] eg,
                                 input logic eb, input logic et);
        vec_t x;
        x.rst = r; x.valid = v; x.data = d; x.last = l; x.full = f;
        x.e_ready = er; x.e_uv = euv; x.e_data = ed; x.e_grant = eg; x.e_busy = eb; x.e_to = et;
        return x;
    endfunction

    task automatic add(input string n, input vec_t v);
        lbl.push_back(n);
        tbl.push_back(v);
    endtask

    // Drive one cycle's inputs just after the rising edge, check on the falling edge.
    task automatic apply(input vec_t v, input string name);
        logic ok;
        @(posedge clk);
        #1;
        rst       = v.rst;
        req_valid = v.valid;
        req_data  = v.data;
        req_last  = v.last;
        uart_full = v.full;
        @(negedge clk);
        tests++;
        ok = (req_ready === v.e_ready) && (uart_valid === v.e_uv) &&
             (!v.e_uv || (uart_data === v.e_data)) && (grant === v.e_grant) &&
             (busy === v.e_busy) && (timeout_err === v.e_to);
        if (!ok) begin
            fails++;
            $display("FAIL %s: got ready=%b uv=%b data=%h grant=%b busy=%b terr=%b, want ready=%b uv=%b data=%h grant=%b busy=%b terr=%b",
                     name, req_ready, uart_valid, uart_data, grant, busy, timeout_err,
                     v.e_ready, v.e_uv, v.e_data, v.e_grant, v.e_busy, v.e_to);
        end
    endtask

    logic [3:0] b_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] b_byte [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    logic [3:0] c_vld  [5] = '{4'b0010, 4'b1011, 4'b0011, 4'b1000, 4'b1111};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000ns");
        $fatal(1);
    end

    initial begin
        // Reset hold before any checks.
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Reset forces outputs low regardless of inputs; then a 3-byte packet.
        add("rst_hold_all", mkv(1'b0, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("rst_hold_one", mkv(1'b0, 4'b0001, 32'h00000041, 4'b0001, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("a_idle_req",   mkv(1'b1, 4'b0001, 32'h00000041, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("a_byte1",      mkv(1'b1, 4'b0001, 32'h00000041, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'h41, 4'b0001, 1'b1, 1'b0));
        add("a_byte2",      mkv(1'b1, 4'b0001, 32'h00000042, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'h42, 4'b0001, 1'b1, 1'b0));
        add("a_byte3_last", mkv(1'b1, 4'b0001, 32'h00000043, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h43, 4'b0001, 1'b1, 1'b0));
        add("a_busy_low",   mkv(1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("rst_between",  mkv(1'b0, 4'b0001, 32'h00000000, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));

        // All four requesters continuously valid with 1-byte packets.
        for (int k = 0; k < 5; k++) begin
            add($sformatf("b_gap%0d", k), mkv(1'b1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0,
                                              4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
            add($sformatf("b_pkt%0d", k), mkv(1'b1, 4'b1111, 32'hA3A2A1A0, 4'b1111, 1'b0,
                                              b_gnt[k], 1'b1, b_byte[k], b_gnt[k], 1'b1, 1'b0));
        end
        add("b_end", mkv(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));

        // uart_full stall mid-packet, with other requesters and the owner toggling valid.
        add("c_idle",  mkv(1'b1, 4'b0010, 32'h00001000, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("c_byte0", mkv(1'b1, 4'b0010, 32'h00001000, 4'b0000, 1'b0, 4'b0010, 1'b1, 8'h10, 4'b0010, 1'b1, 1'b0));
        for (int k = 0; k < 5; k++)
            add($sformatf("c_full%0d", k), mkv(1'b1, c_vld[k], 32'h00001100, 4'b0000, 1'b1,
                                               4'b0000, 1'b0, 8'h00, 4'b0010, 1'b1, 1'b0));
        add("c_resume", mkv(1'b1, 4'b0010, 32'h00001100, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h11, 4'b0010, 1'b1, 1'b0));
        add("c_end",    mkv(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));

        // Requester 2 alone; second search starts at rr_ptr=3 and must wrap.
        add("e_idle",      mkv(1'b1, 4'b0100, 32'h00220000, 4'b0100, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("e_pkt",       mkv(1'b1, 4'b0100, 32'h00220000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h22, 4'b0100, 1'b1, 1'b0));
        add("e_wrap_idle", mkv(1'b1, 4'b0100, 32'h00230000, 4'b0100, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));
        add("e_wrap_pkt",  mkv(1'b1, 4'b0100, 32'h00230000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h23, 4'b0100, 1'b1, 1'b0));
        add("e_end",       mkv(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0));

        for (int k = 0; k < tbl.size(); k++)
            apply(tbl[k], lbl[k]);

        // Timeout: rr_ptr=3, requester 0 wins, then stops sending for 16 cycles.
        apply(mkv(1'b1, 4'b0011, 32'h00006050, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "t_idle");
        for (int i = 0; i < TO; i++)
            apply(mkv(1'b1, 4'b0010, 32'h00006050, 4'b0000, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0001, 1'b1, 1'b0),
                  $sformatf("t_stall%0d", i));
        apply(mkv(1'b1, 4'b0010, 32'h00006050, 4'b0010, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1), "t_timeout_pulse");
        apply(mkv(1'b1, 4'b0010, 32'h00006050, 4'b0010, 1'b0, 4'b0010, 1'b1, 8'h60, 4'b0010, 1'b1, 1'b0), "t_next_grant");
        apply(mkv(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "t_end");

        // Transfer on the limit cycle beats the timeout.
        apply(mkv(1'b1, 4'b0100, 32'h00800000, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "u_idle");
        for (int i = 0; i < TO - 1; i++)
            apply(mkv(1'b1, 4'b0000, 32'h00800000, 4'b0000, 1'b0, 4'b0100, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0),
                  $sformatf("u_stall%0d", i));
        apply(mkv(1'b1, 4'b0100, 32'h00800000, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h80, 4'b0100, 1'b1, 1'b0), "u_xfer_at_limit");
        apply(mkv(1'b1, 4'b0100, 32'h00810000, 4'b0100, 1'b0, 4'b0100, 1'b1, 8'h81, 4'b0100, 1'b1, 1'b0), "u_no_timeout");
        apply(mkv(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "u_end");

        // Reset mid-packet after two bytes, then requester 0 wins first.
        apply(mkv(1'b1, 4'b1000, 32'h71000000, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "s_idle");
        apply(mkv(1'b1, 4'b1000, 32'h71000000, 4'b0000, 1'b0, 4'b1000, 1'b1, 8'h71, 4'b1000, 1'b1, 1'b0), "s_byte1");
        apply(mkv(1'b1, 4'b1000, 32'h72000000, 4'b0000, 1'b0, 4'b1000, 1'b1, 8'h72, 4'b1000, 1'b1, 1'b0), "s_byte2");
        apply(mkv(1'b0, 4'b1000, 32'h73000000, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "s_rst_mid");
        apply(mkv(1'b1, 4'b1111, 32'h94939291, 4'b0000, 1'b0, 4'h0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0), "s_release_idle");
        apply(mkv(1'b1, 4'b1111, 32'h94939291, 4'b0000, 1'b0, 4'b0001, 1'b1, 8'h91, 4'b0001, 1'b1, 1'b0), "s_first_grant");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
